video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the graphics path. It runs entirely on clk_100mhz and uses a pixel clock-enable, replacing the ad-hoc gated pixel clock.
- Produces pixel/line counters, DE, syncs, text-cell counters (glyph row, cell column, text row/column), a programmable line-compare pulse and a frame-start pulse.
- Feeds the text area peripheral, future bitmap layers and the CPU interrupt logic.

---
 rtl/ogege_video_pkg.sv | 37 +++
 rtl/video_timing_gen_pix_ce_div.sv | 47 ++++
 rtl/video_timing_gen.sv | 182 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ogege_video_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ogege_video_pkg
//  Description : Shared definitions for the raster timing path: the default
//                640x480@60 timing set, the sync polarity encoding and a
//                ceiling-log2 helper for sizing counters from parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package ogege_video_pkg;

  // 640x480@60 timing (25 MHz pixel rate)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic {
    SYNC_NEG = 1'b0,
    SYNC_POS = 1'b1
  } sync_pol_t;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : ogege_video_pkg
`default_nettype wire

// File: rtl/video_timing_gen_pix_ce_div.sv
`default_nettype none
// ============================================================================
//  Module      : pix_ce_div
//  Description : Pixel clock-enable divider. A modulo-CLK_DIV counter that
//                starts at 0 after reset release; o_ce is registered and is
//                high while the counter holds CLK_DIV-1, so the first enable
//                is consumed on the CLK_DIV-th clock edge after release.
//  Revision    : 1.0 - initial release
//
//  Ports       : clk   in  system clock
//                rstn  in  asynchronous active-low reset
//                o_ce  out one-clock enable every CLK_DIV clocks
// ============================================================================
module pix_ce_div
  import ogege_video_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic o_ce
);

  localparam int              c_dw   = clog2(CLK_DIV);
  localparam logic [c_dw-1:0] c_last = c_dw'(CLK_DIV - 1);

  logic [c_dw-1:0] r_div;
  logic [c_dw-1:0] w_div_nxt;

  always_comb begin
    w_div_nxt = (r_div == c_last) ? '0 : r_div + c_dw'(1);
  end

  // o_ce is derived from the next divider value so it lines up with the
  // cycle in which the divider holds its terminal count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div <= '0;
      o_ce  <= 1'b0;
    end else begin
      r_div <= w_div_nxt;
      o_ce  <= (w_div_nxt == c_last);
    end
  end

endmodule : pix_ce_div
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing generator running on clk_100mhz with a pixel
//                clock-enable. Produces pixel/line counters, DE, syncs,
//                text-cell counters, a line-compare pulse and a frame-start
//                pulse. All timing outputs are registered from the next-state
//                counts so they change on the same edge as hcount/vcount.
//  Revision    : 1.0 - initial release
//
//  Build option: OGEGE_FRAME_COUNTER_EN adds o_frame_cnt (completed frames).
//
//  Ports       : clk_100mhz    in  system clock
//                rstn_i        in  asynchronous active-low reset
//                i_line_cmp    in  line for o_line_irq, sampled at line start
//                o_pix_ce      out pixel enable, one clk every CLK_DIV clks
//                o_hcount      out pixel within line
//                o_vcount      out line within frame
//                o_de          out active video
//                o_hsync       out horizontal sync (HSYNC_POL active level)
//                o_vsync       out vertical sync (VSYNC_POL active level)
//                o_cell_col    out pixel within glyph
//                o_glyph_row   out line within glyph
//                o_text_col    out text column (saturates at 127)
//                o_text_row    out text row (saturates at 63)
//                o_frame_start out one-clk pulse when counts become (0,0)
//                o_line_irq    out one-clk pulse at start of line i_line_cmp
//                o_frame_cnt   out completed frames (option only)
// ============================================================================
module video_timing_gen
  import ogege_video_pkg::*;
#(
  parameter int        CLK_DIV   = 4,
  parameter int        H_ACTIVE  = VGA_H_ACTIVE,
  parameter int        H_FP      = VGA_H_FP,
  parameter int        H_SYNC    = VGA_H_SYNC,
  parameter int        H_BP      = VGA_H_BP,
  parameter int        V_ACTIVE  = VGA_V_ACTIVE,
  parameter int        V_FP      = VGA_V_FP,
  parameter int        V_SYNC    = VGA_V_SYNC,
  parameter int        V_BP      = VGA_V_BP,
  parameter int        HSZ       = 10,
  parameter int        VSZ       = 10,
  parameter int        GLYPH_W   = 8,
  parameter int        GLYPH_H   = 8,
  parameter sync_pol_t HSYNC_POL = SYNC_NEG,
  parameter sync_pol_t VSYNC_POL = SYNC_NEG
) (
  input  logic                        clk_100mhz,
  input  logic                        rstn_i,
  input  logic [VSZ-1:0]              i_line_cmp,
  output logic                        o_pix_ce,
  output logic [HSZ-1:0]              o_hcount,
  output logic [VSZ-1:0]              o_vcount,
  output logic                        o_de,
  output logic                        o_hsync,
  output logic                        o_vsync,
  output logic [clog2(GLYPH_W)-1:0]   o_cell_col,
  output logic [clog2(GLYPH_H)-1:0]   o_glyph_row,
  output logic [6:0]                  o_text_col,
  output logic [5:0]                  o_text_row,
  output logic                        o_frame_start,
  output logic                        o_line_irq
`ifdef OGEGE_FRAME_COUNTER_EN
  ,
  output logic [15:0]                 o_frame_cnt
`endif
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_cw      = clog2(GLYPH_W);
  localparam int c_gw      = clog2(GLYPH_H);

  localparam logic [HSZ-1:0]  c_h_last   = HSZ'(c_h_total - 1);
  localparam logic [HSZ-1:0]  c_h_act    = HSZ'(H_ACTIVE);
  localparam logic [HSZ-1:0]  c_hs_start = HSZ'(H_ACTIVE + H_FP);
  localparam logic [HSZ-1:0]  c_hs_end   = HSZ'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VSZ-1:0]  c_v_last   = VSZ'(c_v_total - 1);
  localparam logic [VSZ-1:0]  c_v_act    = VSZ'(V_ACTIVE);
  localparam logic [VSZ-1:0]  c_vs_start = VSZ'(V_ACTIVE + V_FP);
  localparam logic [VSZ-1:0]  c_vs_end   = VSZ'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [c_cw-1:0] c_cc_last  = c_cw'(GLYPH_W - 1);
  localparam logic [c_gw-1:0] c_gr_last  = c_gw'(GLYPH_H - 1);
  localparam logic            c_hs_act   = (HSYNC_POL == SYNC_POS);
  localparam logic            c_vs_act   = (VSYNC_POL == SYNC_POS);

  logic [VSZ-1:0] r_line_cmp;
  logic           w_h_wrap;
  logic           w_v_wrap;
  logic [HSZ-1:0] w_hcount_nxt;
  logic [VSZ-1:0] w_vcount_nxt;
  logic           w_de_nxt;
  logic           w_hsync_nxt;
  logic           w_vsync_nxt;

  pix_ce_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_ce_div (
    .clk  (clk_100mhz),
    .rstn (rstn_i),
    .o_ce (o_pix_ce)
  );

  always_comb begin
    w_h_wrap     = (o_hcount == c_h_last);
    w_v_wrap     = (o_vcount == c_v_last);
    w_hcount_nxt = w_h_wrap ? '0 : o_hcount + HSZ'(1);
    w_vcount_nxt = o_vcount;
    if (w_h_wrap) begin
      w_vcount_nxt = w_v_wrap ? '0 : o_vcount + VSZ'(1);
    end
    w_de_nxt    = (w_hcount_nxt < c_h_act) && (w_vcount_nxt < c_v_act);
    w_hsync_nxt = ((w_hcount_nxt >= c_hs_start) && (w_hcount_nxt < c_hs_end))
                  ? c_hs_act : ~c_hs_act;
    w_vsync_nxt = ((w_vcount_nxt >= c_vs_start) && (w_vcount_nxt < c_vs_end))
                  ? c_vs_act : ~c_vs_act;
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_de          <= 1'b0;
      o_hsync       <= ~c_hs_act;
      o_vsync       <= ~c_vs_act;
      o_cell_col    <= '0;
      o_glyph_row   <= '0;
      o_text_col    <= '0;
      o_text_row    <= '0;
      o_frame_start <= 1'b0;
      o_line_irq    <= 1'b0;
      r_line_cmp    <= '0;
`ifdef OGEGE_FRAME_COUNTER_EN
      o_frame_cnt   <= '0;
`endif
    end else begin
      o_frame_start <= 1'b0;
      o_line_irq    <= 1'b0;
      if (o_pix_ce) begin
        o_hcount <= w_hcount_nxt;
        o_vcount <= w_vcount_nxt;
        o_de     <= w_de_nxt;
        o_hsync  <= w_hsync_nxt;
        o_vsync  <= w_vsync_nxt;
        if (w_h_wrap) begin
          o_cell_col <= '0;
          o_text_col <= '0;
          // Compare against the value captured at the previous line start,
          // then capture the current request for the next one. Values
          // outside the frame can never equal a valid vcount.
          o_line_irq <= (w_vcount_nxt == r_line_cmp);
          r_line_cmp <= i_line_cmp;
          if (w_v_wrap) begin
            o_glyph_row   <= '0;
            o_text_row    <= '0;
            o_frame_start <= 1'b1;
`ifdef OGEGE_FRAME_COUNTER_EN
            o_frame_cnt   <= o_frame_cnt + 16'd1;
`endif
          end else if (o_glyph_row == c_gr_last) begin
            o_glyph_row <= '0;
            if (o_text_row != 6'd63) begin
              o_text_row <= o_text_row + 6'd1;
            end
          end else begin
            o_glyph_row <= o_glyph_row + c_gw'(1);
          end
        end else if (o_cell_col == c_cc_last) begin
          o_cell_col <= '0;
          if (o_text_col != 7'd127) begin
            o_text_col <= o_text_col + 7'd1;
          end
        end else begin
          o_cell_col <= o_cell_col + c_cw'(1);
        end
      end
    end
  end

endmodule : video_timing_gen
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen. Two instances with
//                a reduced raster (different divider, glyph size and sync
//                polarity) are compared every clock against a reference that
//                derives the expected raster state from the number of clock
//                edges since reset release using plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;
  import ogege_video_pkg::*;

  localparam int HA = 32, HF = 4, HS = 4, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int A_D = 3, A_GW = 8, A_GH = 8;
  localparam int B_D = 2, B_GW = 4, B_GH = 16;
  localparam int FA = HT * VT * A_D;

  typedef struct {
    int d; int gw; int gh; int pol;
  } cfg_t;

  typedef struct {
    int ce; int h; int v; int de; int hs; int vs; int cc;
    int gr; int tc; int tr; int fs; int irq; int fc;
  } st_t;

  logic       clk_100mhz = 1'b0;
  logic       rstn_i;
  logic [9:0] i_line_cmp;

  always #5 clk_100mhz = ~clk_100mhz;

  logic       a_pix_ce, a_de, a_hsync, a_vsync, a_frame_start, a_line_irq;
  logic [9:0] a_hcount, a_vcount;
  logic [2:0] a_cell_col, a_glyph_row;
  logic [6:0] a_text_col;
  logic [5:0] a_text_row;
  logic       b_pix_ce, b_de, b_hsync, b_vsync, b_frame_start, b_line_irq;
  logic [9:0] b_hcount, b_vcount;
  logic [1:0] b_cell_col;
  logic [3:0] b_glyph_row;
  logic [6:0] b_text_col;
  logic [5:0] b_text_row;
`ifdef OGEGE_FRAME_COUNTER_EN
  logic [15:0] a_fc, b_fc;
`endif

  video_timing_gen #(
    .CLK_DIV(A_D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HSZ(10), .VSZ(10),
    .GLYPH_W(A_GW), .GLYPH_H(A_GH), .HSYNC_POL(SYNC_NEG), .VSYNC_POL(SYNC_NEG)
  ) u_dut_a (
    .clk_100mhz(clk_100mhz), .rstn_i(rstn_i), .i_line_cmp(i_line_cmp),
    .o_pix_ce(a_pix_ce), .o_hcount(a_hcount), .o_vcount(a_vcount), .o_de(a_de),
    .o_hsync(a_hsync), .o_vsync(a_vsync), .o_cell_col(a_cell_col),
    .o_glyph_row(a_glyph_row), .o_text_col(a_text_col), .o_text_row(a_text_row),
    .o_frame_start(a_frame_start), .o_line_irq(a_line_irq)
`ifdef OGEGE_FRAME_COUNTER_EN
    , .o_frame_cnt(a_fc)
`endif
  );

  video_timing_gen #(
    .CLK_DIV(B_D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HSZ(10), .VSZ(10),
    .GLYPH_W(B_GW), .GLYPH_H(B_GH), .HSYNC_POL(SYNC_POS), .VSYNC_POL(SYNC_POS)
  ) u_dut_b (
    .clk_100mhz(clk_100mhz), .rstn_i(rstn_i), .i_line_cmp(i_line_cmp),
    .o_pix_ce(b_pix_ce), .o_hcount(b_hcount), .o_vcount(b_vcount), .o_de(b_de),
    .o_hsync(b_hsync), .o_vsync(b_vsync), .o_cell_col(b_cell_col),
    .o_glyph_row(b_glyph_row), .o_text_col(b_text_col), .o_text_row(b_text_row),
    .o_frame_start(b_frame_start), .o_line_irq(b_line_irq)
`ifdef OGEGE_FRAME_COUNTER_EN
    , .o_frame_cnt(b_fc)
`endif
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  int   k        = 0;   // clock edges since reset release
  int   cmp_eff_a, cmp_eff_b;
  bit   irq_a, irq_b;
  cfg_t cfg_a, cfg_b;

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // Expected raster state after kk edges: one pixel per d edges, pixel
  // index p maps directly onto (h, v) by division.
  function automatic st_t model(input cfg_t c, input int kk, input bit irq);
    st_t e;
    int  p;
    p     = kk / c.d;
    e.ce  = ((kk + 1) % c.d == 0) ? 1 : 0;
    e.h   = p % HT;
    e.v   = (p / HT) % VT;
    e.de  = (p > 0 && e.h < HA && e.v < VA) ? 1 : 0;
    e.hs  = (e.h >= HA + HF && e.h < HA + HF + HS) ? c.pol : 1 - c.pol;
    e.vs  = (e.v >= VA + VF && e.v < VA + VF + VS) ? c.pol : 1 - c.pol;
    e.cc  = e.h % c.gw;
    e.tc  = imin(e.h / c.gw, 127);
    e.gr  = e.v % c.gh;
    e.tr  = imin(e.v / c.gh, 63);
    e.fs  = (kk > 0 && kk % c.d == 0 && p % (HT * VT) == 0) ? 1 : 0;
    e.irq = irq ? 1 : 0;
    e.fc  = (p / (HT * VT)) % 65536;
    return e;
  endfunction

  // Line-compare reference: at each line start the line just entered is
  // compared with the value captured at the previous line start, and the
  // current request is captured.
  task automatic edge_model(input cfg_t c, input int kk, inout int cmp_eff,
                            output bit irq);
    int p;
    irq = 1'b0;
    if (kk % c.d == 0) begin
      p = kk / c.d;
      if (p % HT == 0) begin
        irq     = ((p / HT) % VT == cmp_eff);
        cmp_eff = int'(i_line_cmp);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic chk_st(input string nm, input st_t o, input st_t e);
    chk({nm, ".pix_ce"},      o.ce,  e.ce);
    chk({nm, ".hcount"},      o.h,   e.h);
    chk({nm, ".vcount"},      o.v,   e.v);
    chk({nm, ".de"},          o.de,  e.de);
    chk({nm, ".hsync"},       o.hs,  e.hs);
    chk({nm, ".vsync"},       o.vs,  e.vs);
    chk({nm, ".cell_col"},    o.cc,  e.cc);
    chk({nm, ".glyph_row"},   o.gr,  e.gr);
    chk({nm, ".text_col"},    o.tc,  e.tc);
    chk({nm, ".text_row"},    o.tr,  e.tr);
    chk({nm, ".frame_start"}, o.fs,  e.fs);
    chk({nm, ".line_irq"},    o.irq, e.irq);
`ifdef OGEGE_FRAME_COUNTER_EN
    chk({nm, ".frame_cnt"},   o.fc,  e.fc);
`endif
  endtask

  task automatic check_all();
    st_t oa, ob;
    oa.ce = 32'(a_pix_ce);   oa.h  = 32'(a_hcount);    oa.v  = 32'(a_vcount);
    oa.de = 32'(a_de);       oa.hs = 32'(a_hsync);     oa.vs = 32'(a_vsync);
    oa.cc = 32'(a_cell_col); oa.gr = 32'(a_glyph_row); oa.tc = 32'(a_text_col);
    oa.tr = 32'(a_text_row); oa.fs = 32'(a_frame_start); oa.irq = 32'(a_line_irq);
    ob.ce = 32'(b_pix_ce);   ob.h  = 32'(b_hcount);    ob.v  = 32'(b_vcount);
    ob.de = 32'(b_de);       ob.hs = 32'(b_hsync);     ob.vs = 32'(b_vsync);
    ob.cc = 32'(b_cell_col); ob.gr = 32'(b_glyph_row); ob.tc = 32'(b_text_col);
    ob.tr = 32'(b_text_row); ob.fs = 32'(b_frame_start); ob.irq = 32'(b_line_irq);
`ifdef OGEGE_FRAME_COUNTER_EN
    oa.fc = 32'(a_fc);
    ob.fc = 32'(b_fc);
`else
    oa.fc = 0;
    ob.fc = 0;
`endif
    chk_st("a", oa, model(cfg_a, k, irq_a));
    chk_st("b", ob, model(cfg_b, k, irq_b));
  endtask

  task automatic clear_model();
    k         = 0;
    cmp_eff_a = 0;
    cmp_eff_b = 0;
    irq_a     = 1'b0;
    irq_b     = 1'b0;
  endtask

  // One clock: advance the reference on the rising edge, compare on the
  // falling edge.
  task automatic tick();
    @(posedge clk_100mhz);
    if (rstn_i) begin
      k++;
      edge_model(cfg_a, k, cmp_eff_a, irq_a);
      edge_model(cfg_b, k, cmp_eff_b, irq_b);
    end else begin
      clear_model();
    end
    @(negedge clk_100mhz);
    check_all();
  endtask

  initial begin
    cfg_a = '{d: A_D, gw: A_GW, gh: A_GH, pol: 0};
    cfg_b = '{d: B_D, gw: B_GW, gh: B_GH, pol: 1};
    clear_model();
    rstn_i     = 1'b0;
    i_line_cmp = 10'd5;

    // Held in reset, then released on a falling edge.
    repeat (3) tick();
    rstn_i = 1'b1;

    // Free run with a fixed compare line.
    repeat (2 * FA + 50) tick();

    // Random compare lines inside the frame.
    repeat (3) begin
      i_line_cmp = 10'($urandom_range(1, VT - 1));
      repeat (FA) tick();
    end

    // Compare line 0 coincides with frame start.
    i_line_cmp = 10'd0;
    repeat (FA + 2 * HT * A_D) tick();

    // Compare line beyond the frame never fires.
    i_line_cmp = 10'(VT + $urandom_range(0, 1000 - VT));
    repeat (FA) tick();

    // Asynchronous reset in the middle of a line.
    repeat ((10 * HT + $urandom_range(5, HT - 5)) * A_D) tick();
    #2 rstn_i = 1'b0;
    #1;
    clear_model();
    check_all();
    repeat (4) tick();
    rstn_i     = 1'b1;
    i_line_cmp = 10'($urandom_range(0, VT - 1));
    repeat (3 * FA + 20) tick();
`ifdef OGEGE_FRAME_COUNTER_EN
    chk("a.frame_cnt_after_three", 32'(a_fc), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule : tb_video_timing_gen
`default_nettype wire
